// File: rtl/trace_reorder_queue_pkg.sv
// Shared types and constants for the issue-order trace reorder queue.
// Source latency constants select the insertion slot for each pipeline source.
package trace_reorder_queue_pkg;

  localparam int unsigned TRACE_SLOT_MULTICYCLE = 0;
  localparam int unsigned TRACE_SLOT_MEM        = 3;
  localparam int unsigned TRACE_SLOT_SCYCLE     = 4;
  localparam int unsigned TRACE_SLOT_STORE      = 5;

  typedef enum logic [2:0] {
    TRACE_EV_NONE      = 3'd0,
    TRACE_EV_WRITEBACK = 3'd1,
    TRACE_EV_STORE     = 3'd2,
    TRACE_EV_PC        = 3'd3,
    TRACE_EV_ROLLBACK  = 3'd4
  } trace_event_type_t;

  // Logical event layout; producers and dumpers pack this into EVENT_WIDTH bits.
  typedef struct packed {
    trace_event_type_t ev_type;
    logic [31:0]       pc;
    logic [3:0]        thread_idx;
    logic [4:0]        writeback_reg;
    logic [31:0]       addr;
    logic [3:0]        mask;
    logic [31:0]       data;
  } trace_event_t;

  function automatic logic slot_in_range(input logic [31:0] slot, input int unsigned depth);
    return slot < depth;
  endfunction

endpackage

// File: rtl/trace_event_fifo.sv
// First-word fall-through synchronous FIFO with entry count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trace_event_fifo
  import trace_reorder_queue_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             drop_c
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             full_c, pop_c, push_c;

  always_comb begin
    full_c   = (count_q == CNT_W'(DEPTH));
    pop_c    = pop_i && valid_q;
    push_c   = push_i && (!full_c || pop_c);
    drop_c   = push_i && !push_c;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Storage needs no reset: contents are only visible behind valid_q.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = valid_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/trace_reorder_queue.sv
// Issue-order reorder queue: sources insert at their remaining-latency slot, slot 0
// drains into an output FIFO each cycle, with sticky collision/overflow flags.
module trace_reorder_queue
  import trace_reorder_queue_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned NUM_SOURCES = 3,
  parameter int unsigned EVENT_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH  = 16,
  localparam int unsigned SLOT_W = $clog2(DEPTH),
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_SOURCES-1:0]            src_valid,
  input  logic [NUM_SOURCES*SLOT_W-1:0]     src_slot,
  input  logic [NUM_SOURCES*EVENT_WIDTH-1:0] src_data,
  input  logic                              kill_en,
  input  logic [SLOT_W-1:0]                 kill_slot,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [EVENT_WIDTH-1:0]            out_data,
  output logic [CNT_W-1:0]                  occupancy,
  output logic                              collision,
  output logic                              overflow,
  input  logic                              clear_errors
);

  logic [DEPTH-1:0]       slot_vld_q, slot_vld_d;
  logic [EVENT_WIDTH-1:0] slot_data_q [DEPTH];
  logic [EVENT_WIDTH-1:0] slot_data_d [DEPTH];
  logic                   collision_q, collision_d;
  logic                   overflow_q, overflow_d;
  logic                   insert_clash_c;
  logic                   fifo_drop_c;
  logic [SLOT_W-1:0]      sel_slot_c;

  // Shift toward slot 0, then inserts in source priority order, then kill.
  always_comb begin
    slot_vld_d     = slot_vld_q >> 1;
    insert_clash_c = 1'b0;
    sel_slot_c     = '0;
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      slot_data_d[i] = slot_data_q[i+1];
    end
    slot_data_d[DEPTH-1] = slot_data_q[DEPTH-1];

    for (int s = 0; s < int'(NUM_SOURCES); s++) begin
      sel_slot_c = src_slot[s*SLOT_W +: SLOT_W];
      if (src_valid[s] && slot_in_range(32'(sel_slot_c), DEPTH)) begin
        if (slot_vld_d[sel_slot_c]) begin
          insert_clash_c = 1'b1;
        end else begin
          slot_vld_d[sel_slot_c]  = 1'b1;
          slot_data_d[sel_slot_c] = src_data[s*EVENT_WIDTH +: EVENT_WIDTH];
        end
      end
    end

    if (kill_en && slot_in_range(32'(kill_slot), DEPTH)) begin
      slot_vld_d[kill_slot] = 1'b0;
    end
  end

  // Sticky flags: a new error in the clearing cycle still sets the flag.
  always_comb begin
    collision_d = clear_errors ? 1'b0 : collision_q;
    overflow_d  = clear_errors ? 1'b0 : overflow_q;
    if (insert_clash_c) collision_d = 1'b1;
    if (fifo_drop_c)    overflow_d  = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_vld_q  <= '0;
      collision_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      collision_q <= collision_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    slot_data_q <= slot_data_d;
  end

  trace_event_fifo #(
    .WIDTH (EVENT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (slot_vld_q[0]),
    .push_data_i (slot_data_q[0]),
    .pop_i       (out_ready),
    .valid_o     (out_valid),
    .data_o      (out_data),
    .count_o     (occupancy),
    .drop_c      (fifo_drop_c)
  );

  assign collision = collision_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/trace_reorder_queue.md
Name: trace_reorder_queue

Overview:
- Synthesizable, parametrised issue-order reorder queue for cosimulation and debug event capture.
- Multiple pipeline sources post completed events (writebacks, stores, PC updates) into a shift register. Each event goes into the slot matching that source's remaining latency, so events leave slot 0 in issue order.
- Drained events pass through an output FIFO with a valid/ready handshake, so a UART or debug_trace capture block can apply backpressure.
- Sits beside a core and observes its writeback, store and rollback signals.

Parameters:
- DEPTH, 8, number of reorder slots (≥2).
- NUM_SOURCES, 3, number of independent event insertion ports.
- EVENT_WIDTH, 64, bits per event payload (opaque to this block).
- FIFO_DEPTH, 16, output FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- src_valid  in  NUM_SOURCES  per-source insert request.
- src_slot  in  NUM_SOURCES*$clog2(DEPTH)  per-source target slot, packed with source 0 in the LSBs.
- src_data  in  NUM_SOURCES*EVENT_WIDTH  per-source payload, packed with source 0 in the LSBs.
- kill_en  in  1  invalidate one slot (rollback or failed sync store).
- kill_slot  in  $clog2(DEPTH)  slot to invalidate.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  EVENT_WIDTH  head-of-FIFO event.
- occupancy  out  $clog2(FIFO_DEPTH+1)  FIFO entry count.
- collision  out  1  sticky: an insert was dropped because its slot was taken.
- overflow  out  1  sticky: a drained event was dropped because the FIFO was full.
- clear_errors  in  1  clears collision and overflow.

Behaviour:
- Reset (async):
  - All slot valid bits 0.
  - FIFO empty: out_valid=0, occupancy=0.
  - collision=0, overflow=0.
  - out_data is don't-care while out_valid=0.
- Every clock edge, in this order:
  1. Drain: slot0 is pushed to the FIFO if it is valid.
  2. Shift: slot[i] <= slot[i+1]; slot[DEPTH-1] <= empty.
  3. Insert: each valid source writes its post-shift slot src_slot.
  4. Kill: if kill_en, post-shift slot kill_slot becomes invalid, overriding any same-cycle insert to it.
- Latency: an insert sampled at edge E into slot s is pushed to the FIFO at edge E+s+1. With an empty FIFO, out_valid rises after that edge.
- Conflict rules:
  - If the post-shift slot already holds a valid event, that occupant is kept, the new insert is dropped and collision is set.
  - If several sources target the same slot in one cycle, the lowest-numbered source wins, the others are dropped and collision is set.
- Out-of-range src_slot or kill_slot (possible only when DEPTH is not a power of two) is ignored; collision is not set.
- Output FIFO:
  - First-word fall-through.
  - A pop occurs when out_valid && out_ready.
  - A push is accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the drained event is discarded and overflow is set.
  - Pop on empty is ignored.
  - occupancy is updated every cycle: +1 push, −1 pop, unchanged for both or neither.
- Sticky flags: clear_errors zeroes both. If a new error occurs in the same cycle as clear_errors, set wins.
- Reset mid-operation discards all slot and FIFO contents immediately, with no partial output.
- The event payload is never modified; ordering between events in the same slot is impossible by construction.

Decomposition:
- Shared package: trace_event_type_t and trace_event_t (type, pc, thread_idx, writeback_reg, addr, mask, data). Testbenches and the cosim dumper pack them into EVENT_WIDTH.
- Shared package: the source-latency constants TRACE_SLOT_MULTICYCLE=0, TRACE_SLOT_MEM=3, TRACE_SLOT_SCYCLE=4, TRACE_SLOT_STORE=5.
- One sub-module: trace_event_fifo (parametrised FWFT sync FIFO with count output).

Test Plan:
- Single event: src 0 inserts slot 3 with data 0xA5 at edge 10 → out_valid rises after edge 14, out_data=0xA5, occupancy=1; pop with out_ready → out_valid=0.
- Reordering:
  - At edge 5, src 1 inserts slot 4 with data=1.
  - At edge 6, src 0 inserts slot 0 with data=2.
  - Result: output order is 2 then 1, collision=0.
- Collision:
  - Srcs 0 and 2 both insert slot 2 in the same cycle with data 0x11/0x22 → only 0x11 is emitted and collision=1.
  - clear_errors → collision=0.
- Kill: insert slot 4 data 0x33 together with kill_en, kill_slot=4 in the same cycle → nothing emitted; an insert to slot 4 one cycle earlier followed by kill_slot=3 → also nothing emitted.
- Backpressure: out_ready=0 while 17 events drain → occupancy=16, overflow=1, the first 16 events come out in order, and the 17th is lost. Full with simultaneous pop and push → occupancy stays 16, no overflow.
- Reset with 3 slots and 5 FIFO entries occupied → out_valid=0, occupancy=0, nothing emitted after deassert.
